// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//
// Parameterizable synchronous binary counter with count enable and a
// registered output. It is used as a generic timer, address generator or
// event counter. The default build is a free-running 8-bit up-counter, step 1,
// that wraps from 255 to 0.
//
// Parameters
//   bus_width   : width of out in bits (1..32)
//   step        : amount added/subtracted per enabled edge (1..max_value)
//   count_down  : 0 = count up, 1 = count down
//   max_value   : highest count; the modulus is max_value+1
//   saturate    : 0 = wrap at the limits, 1 = clamp at the limits
//   reset_value : value loaded by rst (<= max_value)
//
// Ports
//   clk : single clock; all state changes on its rising edge
//   rst : synchronous active-high reset; has priority over ebl
//   ebl : active-high count enable; one update per enabled edge
//   out : current count, driven straight from a register
//
// There is no handshake. The counter has one cycle of latency: an enable
// sampled on edge N produces the new count on out right after edge N.
// rst on an edge always loads reset_value, whatever ebl is.
// ---------------------------------------------------------------------------
module counter #(
  parameter int              bus_width   = 8,
  parameter int unsigned     step        = 1,
  parameter bit              count_down  = 1'b0,
  parameter longint unsigned max_value   = (64'd1 << bus_width) - 64'd1,
  parameter bit              saturate    = 1'b0,
  parameter longint unsigned reset_value = 64'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ebl,
  output logic [bus_width-1:0] out
);

  // The arithmetic uses one extra bit. Then out+step and out+modulus cannot
  // overflow before they are compared against the limits.
  localparam int lp_w1 = bus_width + 1;

  localparam logic [bus_width:0]   lp_max    = lp_w1'(max_value);
  localparam logic [bus_width:0]   lp_mod    = lp_w1'(max_value + 64'd1);
  localparam logic [bus_width:0]   lp_step   = lp_w1'(step);
  localparam logic [bus_width-1:0] lp_top    = bus_width'(max_value);
  localparam logic [bus_width-1:0] lp_rstval = bus_width'(reset_value);

  // Bad parameter sets stop elaboration, so they never reach a netlist.
  if (bus_width < 1 || bus_width > 32) begin : g_bad_width
    $error("counter: bus_width must be in 1..32");
  end
  if (step == 0) begin : g_bad_step
    $error("counter: step must be non-zero");
  end
  if (longint'(step) > max_value) begin : g_bad_step_range
    $error("counter: step must not exceed max_value");
  end
  if (max_value > ((64'd1 << bus_width) - 64'd1)) begin : g_bad_max
    $error("counter: max_value does not fit in bus_width bits");
  end
  if (reset_value > max_value) begin : g_bad_reset
    $error("counter: reset_value must be <= max_value");
  end

  logic [bus_width-1:0] r_count;

  logic [bus_width:0]   w_ext;
  logic [bus_width:0]   w_sum;
  logic                 w_up_over;
  logic                 w_down_under;
  logic [bus_width-1:0] w_up_next;
  logic [bus_width-1:0] w_down_next;
  logic [bus_width-1:0] w_next;

  assign w_ext        = {1'b0, r_count};
  assign w_sum        = w_ext + lp_step;
  assign w_up_over    = (w_sum > lp_max);
  assign w_down_under = (w_ext < lp_step);

  // Up direction. When out+step passes max_value, the counter either wraps
  // by one modulus or clamps at max_value. When it overshoots,
  // w_sum >= lp_mod, so the subtraction cannot underflow.
  always_comb begin
    w_up_next = bus_width'(w_sum);
    if (w_up_over) begin
      if (saturate) begin
        w_up_next = lp_top;
      end else begin
        w_up_next = bus_width'(w_sum - lp_mod);
      end
    end
  end

  // Down direction. When step is larger than out, the counter either adds
  // one modulus before subtracting or clamps at zero. The sum
  // out+modulus-step is at most 2*max_value+1, so it fits in lp_w1 bits.
  always_comb begin
    w_down_next = bus_width'(w_ext - lp_step);
    if (w_down_under) begin
      if (saturate) begin
        w_down_next = '0;
      end else begin
        w_down_next = bus_width'(w_ext + lp_mod - lp_step);
      end
    end
  end

  assign w_next = count_down ? w_down_next : w_up_next;

  // There is no initial value, so out stays X until the first sampled reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= lp_rstval;
    end else if (ebl) begin
      r_count <= w_next;
    end
  end

  assign out = r_count;

endmodule

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter
//
// Five counter instances, each with its own rst/ebl:
//   0 : defaults (8-bit, up, step 1, wrap)
//   1 : bus_width 4, max_value 9, step 3, wrap
//   2 : bus_width 4, max_value 9, step 3, saturate
//   3 : down, reset_value 2, step 1, wrap
//   4 : down, reset_value 2, step 1, saturate
// Inputs change mid-cycle. Outputs are sampled 2 time units after the
// rising edge. The expected value for each edge is pushed when the
// stimulus is driven and popped when the output is checked.
// ---------------------------------------------------------------------------
module tb_counter;

  logic       clk;
  logic       rst_v [5];
  logic       ebl_v [5];
  logic [7:0] o0;
  logic [3:0] o1;
  logic [3:0] o2;
  logic [7:0] o3;
  logic [7:0] o4;

  int n_cmp;
  int n_err;

  logic [7:0] exp_q [$];
  int         dut_q [$];

  typedef struct {
    int         d;
    logic       r;
    logic       e;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t vecs [$];

  counter u_def (.clk(clk), .rst(rst_v[0]), .ebl(ebl_v[0]), .out(o0));

  counter #(.bus_width(4), .step(3), .max_value(9), .saturate(1'b0))
    u_m10_wrap (.clk(clk), .rst(rst_v[1]), .ebl(ebl_v[1]), .out(o1));

  counter #(.bus_width(4), .step(3), .max_value(9), .saturate(1'b1))
    u_m10_sat (.clk(clk), .rst(rst_v[2]), .ebl(ebl_v[2]), .out(o2));

  counter #(.count_down(1'b1), .reset_value(2), .saturate(1'b0))
    u_dn_wrap (.clk(clk), .rst(rst_v[3]), .ebl(ebl_v[3]), .out(o3));

  counter #(.count_down(1'b1), .reset_value(2), .saturate(1'b1))
    u_dn_sat (.clk(clk), .rst(rst_v[4]), .ebl(ebl_v[4]), .out(o4));

  // Clock and reset-free startup
  initial begin
    clk = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rst_v[i] = 1'b0;
      ebl_v[i] = 1'b0;
    end
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] out_of(input int d);
    logic [7:0] v;
    case (d)
      0:       v = o0;
      1:       v = {4'h0, o1};
      2:       v = {4'h0, o2};
      3:       v = o3;
      default: v = o4;
    endcase
    return v;
  endfunction

  function automatic void add(input int d, input logic r, input logic e,
                              input logic [7:0] exp, input string nm);
    vec_t v;
    v.d   = d;
    v.r   = r;
    v.e   = e;
    v.exp = exp;
    v.nm  = nm;
    vecs.push_back(v);
  endfunction

  // Scoreboard pop and compare
  task automatic check(input string nm);
    logic [7:0] exp;
    logic [7:0] act;
    int         d;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got empty scoreboard, required one pending value", nm);
      return;
    end
    exp = exp_q.pop_front();
    d   = dut_q.pop_front();
    act = out_of(d);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d (0x%0h), required %0d (0x%0h)",
               nm, d, act, act, exp, exp);
    end
  endtask

  // Driver: one edge of stimulus with its expected output.
  task automatic apply(input int d, input logic r, input logic e,
                       input logic [7:0] exp, input string nm);
    rst_v[d] = r;
    ebl_v[d] = e;
    exp_q.push_back(exp);
    dut_q.push_back(d);
    @(posedge clk);
    #2;
    check(nm);
  endtask

  initial begin
    logic [7:0] cnt;
    logic       e;
    n_cmp = 0;
    n_err = 0;

    // Vector table
    add(0, 1'b1, 1'b0, 8'd0, "def_reset");
    for (int k = 0; k < 3; k++)   add(0, 1'b0, 1'b0, 8'd0, "def_idle_hold");
    for (int k = 1; k <= 15; k++) add(0, 1'b0, 1'b1, 8'(k), "def_count");
    for (int k = 0; k < 5; k++)   add(0, 1'b0, 1'b0, 8'd15, "def_hold15");

    add(1, 1'b1, 1'b0, 8'd0, "m10_wrap_reset");
    add(1, 1'b0, 1'b1, 8'd3, "m10_wrap");
    add(1, 1'b0, 1'b1, 8'd6, "m10_wrap");
    add(1, 1'b0, 1'b1, 8'd9, "m10_wrap");
    add(1, 1'b0, 1'b1, 8'd2, "m10_wrap_over");
    add(1, 1'b0, 1'b1, 8'd5, "m10_wrap");
    add(1, 1'b0, 1'b1, 8'd8, "m10_wrap");
    add(1, 1'b0, 1'b1, 8'd1, "m10_wrap_over");

    add(2, 1'b1, 1'b0, 8'd0, "m10_sat_reset");
    add(2, 1'b0, 1'b1, 8'd3, "m10_sat");
    add(2, 1'b0, 1'b1, 8'd6, "m10_sat");
    add(2, 1'b0, 1'b1, 8'd9, "m10_sat");
    add(2, 1'b0, 1'b1, 8'd9, "m10_sat_clamp");
    add(2, 1'b0, 1'b1, 8'd9, "m10_sat_clamp");

    add(3, 1'b1, 1'b1, 8'd2,   "dn_wrap_reset_pri");
    add(3, 1'b0, 1'b1, 8'd1,   "dn_wrap");
    add(3, 1'b0, 1'b1, 8'd0,   "dn_wrap");
    add(3, 1'b0, 1'b1, 8'd255, "dn_wrap_under");
    add(3, 1'b0, 1'b1, 8'd254, "dn_wrap");

    add(4, 1'b1, 1'b0, 8'd2, "dn_sat_reset");
    add(4, 1'b0, 1'b1, 8'd1, "dn_sat");
    add(4, 1'b0, 1'b1, 8'd0, "dn_sat");
    add(4, 1'b0, 1'b1, 8'd0, "dn_sat_clamp");
    add(4, 1'b0, 1'b1, 8'd0, "dn_sat_clamp");

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].d, vecs[i].r, vecs[i].e, vecs[i].exp, vecs[i].nm);
    end

    // 258 enabled edges from 0, covering the full 8-bit wrap 255 -> 0 -> 1 -> 2
    apply(0, 1'b1, 1'b0, 8'd0, "wrap_reset");
    for (int k = 1; k <= 258; k++) begin
      apply(0, 1'b0, 1'b1, 8'(k), "def_wrap");
    end

    // Reset asserted mid-count with ebl high, then counting resumes
    apply(0, 1'b1, 1'b0, 8'd0, "mid_reset_pre");
    for (int k = 1; k <= 10; k++) begin
      apply(0, 1'b0, 1'b1, 8'(k), "mid_count");
    end
    apply(0, 1'b1, 1'b1, 8'd0, "mid_reset_priority");
    apply(0, 1'b0, 1'b1, 8'd1, "mid_resume");

    // Alternating enable, then a random enable pattern
    cnt = 8'd1;
    for (int k = 0; k < 8; k++) begin
      e = (k % 2 == 1);
      if (e) cnt = cnt + 8'd1;
      apply(0, 1'b0, e, cnt, "ebl_toggle");
    end
    for (int k = 0; k < 40; k++) begin
      e = 1'($urandom_range(0, 1));
      if (e) cnt = cnt + 8'd1;
      apply(0, 1'b0, e, cnt, "ebl_random");
    end

    // Hold behaviour of the modulus-10 saturating counter at its limit when idle
    apply(2, 1'b0, 1'b0, 8'd9, "m10_sat_idle");
    apply(2, 1'b1, 1'b1, 8'd0, "m10_sat_reset_pri");
    apply(2, 1'b0, 1'b1, 8'd3, "m10_sat_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
